wb_port_arbiter: RTL and testbench

- Owns the single register-file write port in the 5-stage RISC-V core.
- Arbitrates between two requesters:
  - the in-order pipeline writeback, taken from the MEM/WB register outputs;
  - a long-latency unit (divider or multi-cycle load) with a valid/ready handshake.
- The pipeline has fixed priority.
- An aging counter prevents the long-latency unit from starving: on timeout the block requests a one-bubble pipeline stall.
- All write-port outputs are registered.

---
 rtl/wb_port_arbiter_pkg.sv | 21 ++
 rtl/wb_arb_age_counter.sv | 28 ++
 rtl/wb_port_arbiter.sv | 135 +++++++++++++
 tb/tb_wb_port_arbiter.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/wb_port_arbiter_pkg.sv
// Shared definitions for the register-file write-port arbiter.
// Arbiter state encoding, register address constants and request helpers.
package wb_port_arbiter_pkg;

  localparam logic ARB_NORMAL = 1'b0;
  localparam logic ARB_STARVE = 1'b1;

  localparam int REG_ADDR_W = 5;
  localparam logic [REG_ADDR_W-1:0] REG_ZERO = 5'd0;

  typedef logic arb_state_t;

  // A write to x0 is architecturally a no-op, so it never claims the port.
  function automatic logic is_wr(
    input logic                  wreg,
    input logic [REG_ADDR_W-1:0] wd
  );
    return wreg && (wd != REG_ZERO);
  endfunction

endpackage

// File: rtl/wb_arb_age_counter.sv
// Aging counter for the long-latency requester of the write-port arbiter.
// Clear has priority over increment; tc flags the last tolerated wait cycle.
module wb_arb_age_counter #(
  parameter int CNT_W    = 8,
  parameter int MAX_WAIT = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic inc,
  output logic tc
);

  logic [CNT_W-1:0] count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (inc) begin
      count <= count + CNT_W'(1);
    end
  end

  assign tc = (count == CNT_W'(MAX_WAIT - 1));

endmodule

// File: rtl/wb_port_arbiter.sv
// Register-file write-port arbiter: pipeline writeback vs long-latency unit.
// Optional statistics counters are built when WB_ARB_STAT_EN is defined.
module wb_port_arbiter
  import wb_port_arbiter_pkg::*;
#(
  parameter int XLEN     = 32,
  parameter int MAX_WAIT = 8,
  parameter int CNT_W    = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  wb_wreg,
  input  logic [REG_ADDR_W-1:0] wb_wd,
  input  logic [XLEN-1:0]       wb_wdata,
  input  logic                  lu_valid,
  input  logic [REG_ADDR_W-1:0] lu_wd,
  input  logic [XLEN-1:0]       lu_wdata,
  output logic                  lu_ready,
  output logic                  stall_req,
  output logic                  rf_we,
  output logic [REG_ADDR_W-1:0] rf_waddr,
  output logic [XLEN-1:0]       rf_wdata
`ifdef WB_ARB_STAT_EN
  ,
  output logic [31:0]           stat_stall_cnt,
  output logic [31:0]           stat_lu_wait_cnt
`endif
);

  arb_state_t state;
  arb_state_t state_nxt;

  logic pipe_req;
  logic pipe_gnt;
  logic lu_gnt;
  logic lu_wait;
  logic lu_wr;
  logic age_inc;
  logic age_clr;
  logic age_tc;

  assign pipe_req = is_wr(wb_wreg, wb_wd);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ARB_NORMAL;
    end else begin
      state <= state_nxt;
    end
  end

  // Pipeline wins in both states; the stall only removes its requests.
  always_comb begin
    state_nxt = state;
    unique case (1'b1)
      (state == ARB_NORMAL): begin
        if (lu_wait && age_tc) begin
          state_nxt = ARB_STARVE;
        end
      end
      (state == ARB_STARVE): begin
        if (!pipe_gnt) begin
          state_nxt = ARB_NORMAL;
        end
      end
      default: state_nxt = ARB_NORMAL;
    endcase
  end

  // Grants are gated by rst_n so a held lu_valid sees no ready in reset.
  always_comb begin
    pipe_gnt = 1'b0;
    lu_gnt   = 1'b0;
    if (rst_n) begin
      if (pipe_req) begin
        pipe_gnt = 1'b1;
      end else if (lu_valid) begin
        lu_gnt = 1'b1;
      end
    end
  end

  assign lu_ready  = lu_gnt;
  assign lu_wait   = lu_valid && !lu_gnt;
  assign lu_wr     = lu_gnt && (lu_wd != REG_ZERO);
  assign stall_req = (state == ARB_STARVE);

  assign age_inc = lu_wait && (state == ARB_NORMAL);
  assign age_clr = !age_inc || age_tc;

  wb_arb_age_counter #(
    .CNT_W    (CNT_W),
    .MAX_WAIT (MAX_WAIT)
  ) u_age (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (age_clr),
    .inc   (age_inc),
    .tc    (age_tc)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rf_we    <= 1'b0;
      rf_waddr <= REG_ZERO;
      rf_wdata <= '0;
    end else begin
      rf_we <= pipe_gnt || lu_wr;
      if (pipe_gnt) begin
        rf_waddr <= wb_wd;
        rf_wdata <= wb_wdata;
      end else if (lu_wr) begin
        rf_waddr <= lu_wd;
        rf_wdata <= lu_wdata;
      end
    end
  end

`ifdef WB_ARB_STAT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_stall_cnt   <= '0;
      stat_lu_wait_cnt <= '0;
    end else begin
      if (stall_req && (stat_stall_cnt != '1)) begin
        stat_stall_cnt <= stat_stall_cnt + 32'd1;
      end
      if (lu_wait && (stat_lu_wait_cnt != '1)) begin
        stat_lu_wait_cnt <= stat_lu_wait_cnt + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Scoreboard bench for wb_port_arbiter with directed stimulus.
// Build with WB_ARB_STAT_EN to also cover the statistics ports.
module tb_wb_port_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        wb_wreg;
  logic [4:0]  wb_wd;
  logic [31:0] wb_wdata;
  logic        lu_valid;
  logic [4:0]  lu_wd;
  logic [31:0] lu_wdata;
  logic        lu_ready;
  logic        stall_req;
  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
`ifdef WB_ARB_STAT_EN
  logic [31:0] stat_stall_cnt;
  logic [31:0] stat_lu_wait_cnt;
`endif

  wb_port_arbiter #(
    .XLEN     (32),
    .MAX_WAIT (8),
    .CNT_W    (8)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .wb_wreg   (wb_wreg),
    .wb_wd     (wb_wd),
    .wb_wdata  (wb_wdata),
    .lu_valid  (lu_valid),
    .lu_wd     (lu_wd),
    .lu_wdata  (lu_wdata),
    .lu_ready  (lu_ready),
    .stall_req (stall_req),
    .rf_we     (rf_we),
    .rf_waddr  (rf_waddr),
    .rf_wdata  (rf_wdata)
`ifdef WB_ARB_STAT_EN
    ,
    .stat_stall_cnt   (stat_stall_cnt),
    .stat_lu_wait_cnt (stat_lu_wait_cnt)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [4:0]  a;
    logic [31:0] d;
    int          c;
  } exp_t;

  exp_t sb[$];
  int   cyc   = 0;
  int   total = 0;
  int   bad   = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Every write on the port must match the oldest expected entry.
  always @(negedge clk) begin
    if (rf_we === 1'b1) begin
      total++;
      if (sb.size() == 0) begin
        bad++;
        $display("FAIL unexpected_write: got addr=%0d data=%0h at cyc=%0d, want none",
                 rf_waddr, rf_wdata, cyc);
      end else begin
        exp_t e;
        e = sb.pop_front();
        if (rf_waddr !== e.a || rf_wdata !== e.d || cyc != e.c) begin
          bad++;
          $display("FAIL write: got addr=%0d data=%0h cyc=%0d, want addr=%0d data=%0h cyc=%0d",
                   rf_waddr, rf_wdata, cyc, e.a, e.d, e.c);
        end
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s: got=%0h want=%0h", nm, act, want);
    end
  endtask

  task automatic drive(input logic w, input logic [4:0] wd,
                       input logic [31:0] wdat, input logic lv,
                       input logic [4:0] lwd, input logic [31:0] ldat);
    @(posedge clk);
    #1;
    wb_wreg  = w;
    wb_wd    = wd;
    wb_wdata = wdat;
    lu_valid = lv;
    lu_wd    = lwd;
    lu_wdata = ldat;
  endtask

  task automatic expect_wr(input logic [4:0] a, input logic [31:0] d);
    exp_t e;
    e.a = a;
    e.d = d;
    e.c = cyc + 1;
    sb.push_back(e);
  endtask

  task automatic idle();
    drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    @(negedge clk);
  endtask

  initial begin
    rst_n    = 1'b0;
    wb_wreg  = 1'b0;
    wb_wd    = 5'd0;
    wb_wdata = 32'd0;
    lu_valid = 1'b0;
    lu_wd    = 5'd0;
    lu_wdata = 32'd0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_rf_we", 32'(rf_we), 32'd0);
    chk("rst_rf_waddr", 32'(rf_waddr), 32'd0);
    chk("rst_rf_wdata", rf_wdata, 32'd0);
    chk("rst_stall", 32'(stall_req), 32'd0);
    rst_n = 1'b1;
    idle();

    // pipe only, then pipe write to x0
    drive(1'b1, 5'd5, 32'h1234, 1'b0, 5'd0, 32'd0);
    expect_wr(5'd5, 32'h1234);
    @(negedge clk);
    chk("pipe_lu_ready", 32'(lu_ready), 32'd0);
    drive(1'b1, 5'd0, 32'h9999, 1'b0, 5'd0, 32'd0);
    @(negedge clk);
    idle();

    // lu only
    drive(1'b0, 5'd0, 32'd0, 1'b1, 5'd10, 32'hDEADBEEF);
    @(negedge clk);
    chk("lu_only_ready", 32'(lu_ready), 32'd1);
    expect_wr(5'd10, 32'hDEADBEEF);
    idle();

    // collision: pipe first, lu on next idle pipe cycle
    drive(1'b1, 5'd3, 32'h33, 1'b1, 5'd4, 32'h44);
    expect_wr(5'd3, 32'h33);
    @(negedge clk);
    chk("coll_ready0", 32'(lu_ready), 32'd0);
    drive(1'b0, 5'd0, 32'd0, 1'b1, 5'd4, 32'h44);
    @(negedge clk);
    chk("coll_ready1", 32'(lu_ready), 32'd1);
    expect_wr(5'd4, 32'h44);
    idle();

    // starvation with MAX_WAIT=8
    for (int i = 1; i <= 8; i++) begin
      drive(1'b1, 5'(i + 10), 32'(i), 1'b1, 5'd4, 32'hCAFE);
      expect_wr(5'(i + 10), 32'(i));
      @(negedge clk);
      chk($sformatf("starve_c%0d_stall", i), 32'(stall_req), 32'd0);
      chk($sformatf("starve_c%0d_ready", i), 32'(lu_ready), 32'd0);
    end
    drive(1'b1, 5'd20, 32'h99, 1'b1, 5'd4, 32'hCAFE);
    expect_wr(5'd20, 32'h99);
    @(negedge clk);
    chk("starve_c9_stall", 32'(stall_req), 32'd1);
    chk("starve_c9_ready", 32'(lu_ready), 32'd0);
    drive(1'b0, 5'd0, 32'd0, 1'b1, 5'd4, 32'hCAFE);
    @(negedge clk);
    chk("starve_c10_stall", 32'(stall_req), 32'd1);
    chk("starve_c10_ready", 32'(lu_ready), 32'd1);
    expect_wr(5'd4, 32'hCAFE);
    idle();
    chk("starve_c11_stall", 32'(stall_req), 32'd0);
`ifdef WB_ARB_STAT_EN
    chk("stat_stall_cnt", stat_stall_cnt, 32'd2);
`endif
    idle();

    // lu write to x0 completes, no write
    drive(1'b0, 5'd0, 32'd0, 1'b1, 5'd0, 32'h55);
    @(negedge clk);
    chk("lu_x0_ready", 32'(lu_ready), 32'd1);
    idle();

    // pipe write to x0 leaves slot free for lu
    drive(1'b1, 5'd0, 32'h66, 1'b1, 5'd7, 32'h77);
    @(negedge clk);
    chk("pipe_x0_lu_ready", 32'(lu_ready), 32'd1);
    expect_wr(5'd7, 32'h77);
    idle();

    // reset mid-run with lu_valid held
    drive(1'b1, 5'd9, 32'hAA, 1'b1, 5'd12, 32'hBB);
    #1 rst_n = 1'b0;
    @(negedge clk);
    chk("midrst_ready", 32'(lu_ready), 32'd0);
    chk("midrst_we", 32'(rf_we), 32'd0);
    chk("midrst_stall", 32'(stall_req), 32'd0);
    drive(1'b0, 5'd0, 32'd0, 1'b1, 5'd12, 32'hBB);
    @(negedge clk);
    chk("midrst_ready2", 32'(lu_ready), 32'd0);
    chk("midrst_waddr", 32'(rf_waddr), 32'd0);
    #1 rst_n = 1'b1;
    #1;
    chk("postrst_ready", 32'(lu_ready), 32'd1);
    expect_wr(5'd12, 32'hBB);
    idle();
    idle();
    idle();

    chk("sb_empty", 32'(sb.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
